// File: rtl/spdif_bmc_rx_if.sv
// Line input and decoded-sample output bundle of the SPDIF/AES3 biphase-mark receiver.
interface spdif_bmc_rx_if #(
  parameter int WIDTH = 16
);
  logic             dataDMC;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             chan_b;
  logic             block_start;
  logic             v_bit;
  logic             u_bit;
  logic             c_bit;
  logic             parity_err;
  logic             locked;
  logic             err;
  logic [1:0]       dbg_state;

  // sample_valid is a one-cycle strobe with no ready: sample and flags must be taken in
  // that cycle; they are then held until the next strobe. err is an independent strobe.
  modport master (
    input  dataDMC,
    output sample, sample_valid, chan_b, block_start, v_bit, u_bit, c_bit,
           parity_err, locked, err, dbg_state
  );
  modport slave (
    output dataDMC,
    input  sample, sample_valid, chan_b, block_start, v_bit, u_bit, c_bit,
           parity_err, locked, err, dbg_state
  );
endinterface

// File: rtl/spdif_bmc_rx.sv
// SPDIF/AES3 biphase-mark receiver: oversamples the line, classifies run lengths,
// locks to B/M/W preambles and emits one audio sample per subframe.
module spdif_bmc_rx #(
  parameter int WIDTH   = 16,
  parameter int HALF_UI = 4
) (
  input  logic           clk1,
  input  logic           nrst,
  spdif_bmc_rx_if.master bus
);
  localparam int RMAX = 4 * HALF_UI;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] T_GL  = RW'(HALF_UI / 2);
  localparam logic [RW-1:0] T_S   = RW'(3 * HALF_UI / 2);
  localparam logic [RW-1:0] T_L   = RW'(5 * HALF_UI / 2);
  localparam logic [RW-1:0] T_X   = RW'(7 * HALF_UI / 2);
  localparam logic [RW-1:0] R_SAT = RW'(RMAX);

  typedef enum logic [1:0] {HUNT, PRE, DATA, PREX} state_t;
  typedef enum logic [2:0] {RC_NONE, RC_GLITCH, RC_S, RC_L, RC_X, RC_TO} run_t;

  logic [2:0]    sync_q;
  logic [RW-1:0] r_q, r_d;
  logic          edge_w;
  run_t          run;

  state_t      state_q, state_d;
  logic [1:0]  pre_cnt_q, pre_cnt_d;
  run_t        pre0_q, pre0_d, pre1_q, pre1_d;
  logic [4:0]  idx_q, idx_d;
  logic        half_q, half_d;
  logic [26:0] sh_q, sh_d;
  logic        chb_pend_q, chb_pend_d, blk_pend_q, blk_pend_d;

  logic [WIDTH-1:0] sample_q, sample_d;
  logic sv_q, sv_d, chan_b_q, chan_b_d, blk_q, blk_d;
  logic v_q, v_d, u_q, u_d, c_q, c_d, perr_q, perr_d;
  logic locked_q, locked_d, err_q, err_d;

  logic        bit_ok, bit_val, fail;
  logic [27:0] full_w;

  assign edge_w = sync_q[2] ^ sync_q[1];

  always_comb begin
    if (edge_w)              r_d = RW'(1);
    else if (r_q != R_SAT)   r_d = r_q + RW'(1);
    else                     r_d = r_q;
  end

  // A missing edge is reported once, in the cycle the run counter reaches the timeout.
  always_comb begin
    run = RC_NONE;
    if (edge_w) begin
      if (r_q < T_GL)      run = RC_GLITCH;
      else if (r_q < T_S)  run = RC_S;
      else if (r_q < T_L)  run = RC_L;
      else if (r_q < T_X)  run = RC_X;
      else                 run = RC_TO;
    end else if (r_q == T_X) begin
      run = RC_TO;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    pre0_d     = pre0_q;
    pre1_d     = pre1_q;
    idx_d      = idx_q;
    half_d     = half_q;
    sh_d       = sh_q;
    chb_pend_d = chb_pend_q;
    blk_pend_d = blk_pend_q;
    sample_d   = sample_q;
    sv_d       = 1'b0;
    chan_b_d   = chan_b_q;
    blk_d      = blk_q;
    v_d        = v_q;
    u_d        = u_q;
    c_d        = c_q;
    perr_d     = perr_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    bit_ok     = 1'b0;
    bit_val    = 1'b0;
    fail       = 1'b0;
    full_w     = {1'b0, sh_q};

    unique case (state_q)
      HUNT: begin
        if (run == RC_X) begin
          state_d   = PRE;
          pre_cnt_d = 2'd0;
        end
      end
      PRE: begin
        if (run == RC_GLITCH || run == RC_TO) begin
          fail = 1'b1;
        end else if (run != RC_NONE) begin
          if (pre_cnt_q == 2'd0) begin
            pre0_d    = run;
            pre_cnt_d = 2'd1;
          end else if (pre_cnt_q == 2'd1) begin
            pre1_d    = run;
            pre_cnt_d = 2'd2;
          end else begin
            idx_d   = 5'd4;
            half_d  = 1'b0;
            state_d = DATA;
            if (pre0_q == RC_S && pre1_q == RC_S && run == RC_X) begin
              chb_pend_d = 1'b0;
              blk_pend_d = 1'b1;
            end else if (pre0_q == RC_X && pre1_q == RC_S && run == RC_S) begin
              chb_pend_d = 1'b0;
              blk_pend_d = 1'b0;
            end else if (pre0_q == RC_L && pre1_q == RC_S && run == RC_L) begin
              chb_pend_d = 1'b1;
              blk_pend_d = 1'b0;
            end else begin
              fail = 1'b1;
            end
          end
        end
      end
      DATA: begin
        case (run)
          RC_NONE: ;
          RC_S: begin
            if (half_q) begin
              bit_ok  = 1'b1;
              bit_val = 1'b1;
              half_d  = 1'b0;
            end else begin
              half_d = 1'b1;
            end
          end
          RC_L: begin
            if (half_q) fail = 1'b1;
            else        bit_ok = 1'b1;
          end
          default: fail = 1'b1;
        endcase
      end
      PREX: begin
        if (run == RC_X) begin
          state_d   = PRE;
          pre_cnt_d = 2'd0;
        end else if (run != RC_NONE) begin
          fail = 1'b1;
        end
      end
    endcase

    // Bits enter at the top, so after slot 31 the word holds slot 4 in bit 0.
    if (bit_ok) begin
      full_w = {bit_val, sh_q};
      sh_d   = full_w[27:1];
      idx_d  = idx_q + 5'd1;
      if (idx_q == 5'd31) begin
        sample_d = full_w[23 -: WIDTH];
        v_d      = full_w[24];
        u_d      = full_w[25];
        c_d      = full_w[26];
        perr_d   = ^full_w;
        chan_b_d = chb_pend_q;
        blk_d    = blk_pend_q;
        sv_d     = 1'b1;
        locked_d = 1'b1;
        state_d  = PREX;
      end
    end

    if (fail) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      state_d  = HUNT;
    end
  end

  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      sync_q     <= '0;
      r_q        <= '0;
      state_q    <= HUNT;
      pre_cnt_q  <= '0;
      pre0_q     <= RC_NONE;
      pre1_q     <= RC_NONE;
      idx_q      <= '0;
      half_q     <= 1'b0;
      sh_q       <= '0;
      chb_pend_q <= 1'b0;
      blk_pend_q <= 1'b0;
      sample_q   <= '0;
      sv_q       <= 1'b0;
      chan_b_q   <= 1'b0;
      blk_q      <= 1'b0;
      v_q        <= 1'b0;
      u_q        <= 1'b0;
      c_q        <= 1'b0;
      perr_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], bus.dataDMC};
      r_q        <= r_d;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      pre0_q     <= pre0_d;
      pre1_q     <= pre1_d;
      idx_q      <= idx_d;
      half_q     <= half_d;
      sh_q       <= sh_d;
      chb_pend_q <= chb_pend_d;
      blk_pend_q <= blk_pend_d;
      sample_q   <= sample_d;
      sv_q       <= sv_d;
      chan_b_q   <= chan_b_d;
      blk_q      <= blk_d;
      v_q        <= v_d;
      u_q        <= u_d;
      c_q        <= c_d;
      perr_q     <= perr_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = sv_q;
  assign bus.chan_b       = chan_b_q;
  assign bus.block_start  = blk_q;
  assign bus.v_bit        = v_q;
  assign bus.u_bit        = u_q;
  assign bus.c_bit        = c_q;
  assign bus.parity_err   = perr_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_spdif_bmc_rx.sv
// Bench for spdif_bmc_rx: a run-length line encoder drives subframes, a monitor
// pops expected samples from a queue on every sample_valid strobe.
module tb_spdif_bmc_rx;
  localparam int WIDTH = 16;
  localparam int H     = 4;
  localparam int EW    = WIDTH + 7;
  localparam int PRE_B = 0;
  localparam int PRE_M = 1;
  localparam int PRE_W = 2;

  logic clk1 = 1'b0;
  logic nrst = 1'b0;
  logic line = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   err_base = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset
  always #5 clk1 = ~clk1;

  spdif_bmc_rx_if #(.WIDTH(WIDTH)) bus ();
  assign bus.dataDMC = line;

  spdif_bmc_rx #(.WIDTH(WIDTH), .HALF_UI(H)) dut (
    .clk1 (clk1),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH+8:0] outs();
    return {bus.sample, bus.sample_valid, bus.chan_b, bus.block_start, bus.v_bit,
            bus.u_bit, bus.c_bit, bus.parity_err, bus.locked, bus.err};
  endfunction

  function automatic logic [23:0] rnd24();
    return 24'($urandom());
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk1);
  endtask

  // Hold the line for a run of 'halves' half-cells, then toggle.
  task automatic run(input int halves, input bit jit);
    int n;
    n = halves * H;
    if (jit) n = n + int'($urandom_range(2)) - 1;
    repeat (n) @(negedge clk1);
    line = ~line;
  endtask

  task automatic send(input int pre, input logic [23:0] audio, input logic [2:0] vuc,
                      input bit flip_p, input int from_slot, input int to_slot, input bit jit);
    logic [27:0] word;
    word[23:0] = audio;
    word[24]   = vuc[0];
    word[25]   = vuc[1];
    word[26]   = vuc[2];
    word[27]   = (^{vuc, audio}) ^ flip_p;
    if (from_slot == 4 && to_slot == 32)
      exp_q.push_back({audio[23 -: WIDTH], pre == PRE_W, pre == PRE_B,
                       vuc[0], vuc[1], vuc[2], flip_p, 1'b1});
    if (from_slot == 4) begin
      case (pre)
        PRE_B:   begin run(3, jit); run(1, jit); run(1, jit); run(3, jit); end
        PRE_M:   begin run(3, jit); run(3, jit); run(1, jit); run(1, jit); end
        default: begin run(3, jit); run(2, jit); run(1, jit); run(2, jit); end
      endcase
    end
    for (int s = from_slot; s < to_slot; s++) begin
      if (word[s-4]) begin
        run(1, jit);
        run(1, jit);
      end else begin
        run(2, jit);
      end
    end
  endtask

  task automatic begin_burst();
    err_base = err_seen;
    idle(40);
    line = ~line;
  endtask

  task automatic end_burst(input string name, input int exp_err);
    idle(40);
    check({name, "_err_count"}, 64'(err_seen - err_base), 64'(exp_err));
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [EW-1:0] got;
    forever begin
      @(negedge clk1);
      if (nrst && bus.err) err_seen++;
      if (nrst && bus.sample_valid) begin
        got = {bus.sample, bus.chan_b, bus.block_start, bus.v_bit, bus.u_bit,
               bus.c_bit, bus.parity_err, bus.locked};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%0h required=none", got);
        end else begin
          check("strobe", 64'(got), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : stim
    logic        lvl0;
    logic [23:0] a;
    logic [2:0]  vuc;

    idle(4);
    check("reset_outputs", 64'(outs()), 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'd0);
    nrst = 1'b1;

    // directed B then W
    lvl0 = line;
    begin_burst();
    send(PRE_B, 24'hA5C300, 3'b000, 1'b0, 4, 32, 1'b0);
    send(PRE_W, 24'h123400, 3'b000, 1'b0, 4, 32, 1'b0);
    end_burst("basic", 1);

    // same stream, inverted line
    if (line == lvl0) line = ~line;
    begin_burst();
    send(PRE_B, 24'hA5C300, 3'b000, 1'b0, 4, 32, 1'b0);
    send(PRE_W, 24'h123400, 3'b000, 1'b0, 4, 32, 1'b0);
    end_burst("inverted", 1);

    // flipped parity on an M subframe
    begin_burst();
    send(PRE_B, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_W, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_M, 24'hFFFF00, 3'b000, 1'b1, 4, 32, 1'b0);
    send(PRE_W, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    end_burst("parity", 1);

    // line stuck during DATA, then three clean subframes
    begin_burst();
    send(PRE_B, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_W, rnd24(), 3'($urandom()), 1'b0, 4, 12, 1'b0);
    idle(24);
    check("hold_locked", 64'(bus.locked), 64'd0);
    check("hold_state", 64'(bus.dbg_state), 64'd0);
    line = ~line;
    send(PRE_B, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_W, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_M, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    end_burst("hold", 2);

    // S followed by L inside DATA
    begin_burst();
    send(PRE_B, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_W, rnd24(), 3'($urandom()), 1'b0, 4, 10, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);
    send(PRE_B, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    send(PRE_W, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    end_burst("s_then_l", 2);

    // reset at slot 15; slot 15 is a one so the first run after release stays short
    begin_burst();
    send(PRE_B, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    a   = rnd24() | 24'h000800;
    vuc = 3'($urandom());
    send(PRE_W, a, vuc, 1'b0, 4, 15, 1'b0);
    nrst = 1'b0;
    #1;
    check("midreset_outputs", 64'(outs()), 64'd0);
    idle(3);
    nrst = 1'b1;
    send(PRE_W, a, vuc, 1'b0, 15, 32, 1'b0);
    send(PRE_M, rnd24(), 3'($urandom()), 1'b0, 4, 32, 1'b0);
    end_burst("reset", 1);

    // randomized subframes with run-length jitter
    begin_burst();
    for (int i = 0; i < 10; i++)
      send((i == 0) ? PRE_B : ((i % 2 == 1) ? PRE_W : PRE_M), rnd24(), 3'($urandom()),
           ($urandom_range(4) == 0), 4, 32, 1'b1);
    end_burst("random", 1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
